// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Instruction-fetch stage of the 16-bit pipelined processor. Holds the program
// counter and a word-addressed instruction memory, and fetches one instruction
// per cycle into the IF/ID pipeline register that drives the decoding stage.
//
// Per-edge update priority (high to low):
//   branch_taken : pc <= branch_target, IF/ID <= bubble
//   flush        : pc <= pc + 1,        IF/ID <= bubble
//   stall        : pc and IF/ID hold
//   otherwise    : IF/ID <= {imem[pc], pc, pc + 1, valid}, pc <= pc + 1
// A bubble is NOP_INSTR with instr_pc, instr_pc_plus1 and instr_valid all zero.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset (imem is not cleared)
//   stall          in   hold pc and IF/ID
//   flush          in   replace IF/ID with a bubble, pc still advances
//   branch_taken   in   redirect pc to branch_target, IF/ID becomes a bubble
//   branch_target  in   redirect address
//   imem_wr_en     in   program-load write enable (synchronous)
//   imem_wr_addr   in   program-load address
//   imem_wr_data   in   program-load data
//   pc             out  current fetch address
//   instruction    out  IF/ID instruction word
//   instr_pc       out  IF/ID address of the instruction
//   instr_pc_plus1 out  IF/ID instr_pc + 1, wrapping
//   instr_valid    out  IF/ID holds a real (non-bubble) instruction
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int unsigned                ADDR_WIDTH  = 10,
    parameter int unsigned                INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   imem_wr_en,
    input  logic [ADDR_WIDTH-1:0]  imem_wr_addr,
    input  logic [INSTR_WIDTH-1:0] imem_wr_data,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [ADDR_WIDTH-1:0]  instr_pc_plus1,
    output logic                   instr_valid
);

    localparam int unsigned           Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PcOne = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Instruction memory: synchronous write, combinational read at pc.
    // A same-cycle write and fetch to one address returns the old word because
    // the write only lands at the edge that also captures the fetch.
    // ------------------------------------------------------------------------
    logic [INSTR_WIDTH-1:0] imem_q [Depth];
    logic [INSTR_WIDTH-1:0] fetch_word;

    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            imem_q[imem_wr_addr] <= imem_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // PC and IF/ID register
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pc_plus1;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_plus1_q, instr_pc_plus1_d;
    logic                   valid_q, valid_d;

    assign fetch_word = imem_q[pc_q];
    assign pc_plus1   = pc_q + PcOne;  // wraps naturally at ADDR_WIDTH bits

    always_comb begin
        // Default: hold everything (covers the stall case).
        pc_d             = pc_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus1_d = instr_pc_plus1_q;
        valid_d          = valid_q;

        if (branch_taken) begin
            // The word fetched this cycle is on the wrong path; drop it.
            pc_d             = branch_target;
            instr_d          = NOP_INSTR;
            instr_pc_d       = '0;
            instr_pc_plus1_d = '0;
            valid_d          = 1'b0;
        end else if (flush) begin
            pc_d             = pc_plus1;
            instr_d          = NOP_INSTR;
            instr_pc_d       = '0;
            instr_pc_plus1_d = '0;
            valid_d          = 1'b0;
        end else if (!stall) begin
            pc_d             = pc_plus1;
            instr_d          = fetch_word;
            instr_pc_d       = pc_q;
            instr_pc_plus1_d = pc_plus1;
            valid_d          = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            instr_q          <= NOP_INSTR;
            instr_pc_q       <= '0;
            instr_pc_plus1_q <= '0;
            valid_q          <= 1'b0;
        end else begin
            pc_q             <= pc_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            instr_pc_plus1_q <= instr_pc_plus1_d;
            valid_q          <= valid_d;
        end
    end

    assign pc             = pc_q;
    assign instruction    = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus1 = instr_pc_plus1_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic [9:0]  pc;
    logic [15:0] instruction;
    logic [9:0]  instr_pc;
    logic [9:0]  instr_pc_plus1;
    logic        instr_valid;

    instruction_fetch_stage #(
        .ADDR_WIDTH  (10),
        .INSTR_WIDTH (16),
        .RESET_PC    (10'd0),
        .NOP_INSTR   (16'h0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_wr_en     (imem_wr_en),
        .imem_wr_addr   (imem_wr_addr),
        .imem_wr_data   (imem_wr_data),
        .pc             (pc),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_pc_plus1 (instr_pc_plus1),
        .instr_valid    (instr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {instruction, instr_pc, instr_pc_plus1, instr_valid, pc}
    typedef struct packed {
        logic [15:0] ins;
        logic [9:0]  ipc;
        logic [9:0]  ipc1;
        logic        v;
        logic [9:0]  pc;
    } obs_t;

    localparam obs_t ResetObs = '{ins: 16'h0, ipc: 10'd0, ipc1: 10'd0, v: 1'b0, pc: 10'd0};

    int   errors = 0;
    int   checks = 0;
    obs_t sb_q[$];

    // Reference model state
    logic [15:0] m_mem [1024];
    logic [9:0]  m_pc;
    logic [15:0] m_ins;
    logic [9:0]  m_ipc;
    logic [9:0]  m_ipc1;
    logic        m_v;

    function automatic obs_t observe();
        obs_t o;
        o = {instruction, instr_pc, instr_pc_plus1, instr_valid, pc};
        return o;
    endfunction

    function automatic logic [15:0] pat(input logic [9:0] a);
        return {a[5:0], a} ^ 16'hA5C3;
    endfunction

    task automatic model_reset();
        m_pc  = 10'd0;
        m_ins = 16'h0;
        m_ipc = 10'd0;
        m_ipc1 = 10'd0;
        m_v   = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle of controls, predict the IF/ID result, push it, take the edge.
    task automatic cyc(input logic s, input logic f, input logic b, input logic [9:0] t,
                       input logic we, input logic [9:0] wa, input logic [15:0] wd);
        obs_t e;
        stall = s; flush = f; branch_taken = b; branch_target = t;
        imem_wr_en = we; imem_wr_addr = wa; imem_wr_data = wd;
        if (b) begin
            m_pc = t; m_ins = 16'h0; m_ipc = 10'd0; m_ipc1 = 10'd0; m_v = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 10'd1; m_ins = 16'h0; m_ipc = 10'd0; m_ipc1 = 10'd0; m_v = 1'b0;
        end else if (!s) begin
            m_ins = m_mem[m_pc]; m_ipc = m_pc; m_ipc1 = m_pc + 10'd1; m_v = 1'b1;
            m_pc = m_pc + 10'd1;
        end
        if (we) m_mem[wa] = wd;  // after the fetch: same-cycle fetch sees old data
        e = {m_ins, m_ipc, m_ipc1, m_v, m_pc};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        stall = 0; flush = 0; branch_taken = 0; imem_wr_en = 0;
    endtask

    task automatic test_reset();
        obs_t a;
        reset = 1'b1;
        stall = 0; flush = 0; branch_taken = 0; branch_target = '0;
        imem_wr_en = 0; imem_wr_addr = '0; imem_wr_data = '0;
        // Program load while held in reset.
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] ad;
            logic [15:0] d;
            ad = i[9:0];
            case (ad)
                10'h000: d = 16'h1111;
                10'h001: d = 16'h2222;
                10'h002: d = 16'h3333;
                10'h003: d = 16'h4444;
                10'h100: d = 16'hABCD;
                10'h3FF: d = 16'hBEEF;
                default: d = pat(ad);
            endcase
            m_mem[ad] = d;
            imem_wr_en = 1; imem_wr_addr = ad; imem_wr_data = d;
            @(posedge clk);
            #1;
        end
        imem_wr_en = 0;
        model_reset();
        a = observe();
        checks++;
        if (a !== ResetObs) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", a, ResetObs);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        obs_t e, a;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, '0, 0, '0, '0);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL seq_edge%0d: got %h required %h", i + 1, a, e);
            end
        end
        checks++;
        if (pc !== 10'd4 || instruction !== 16'h4444 || instr_pc !== 10'd3) begin
            errors++;
            $display("FAIL seq_end: got pc=%h ins=%h ipc=%h required pc=004 ins=4444 ipc=003",
                     pc, instruction, instr_pc);
        end
    endtask

    task automatic test_stall();
        obs_t e, a;
        logic [1:0] ctl [6];  // {stall, branch}
        ctl = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 6; i++) begin
            cyc(ctl[i][1], 0, ctl[i][0], 10'd0, 0, '0, '0);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stall_step%0d: got %h required %h", i, a, e);
            end
            if (i == 4) begin
                checks++;
                if (instruction !== 16'h2222 || pc !== 10'd2) begin
                    errors++;
                    $display("FAIL stall_frozen: got ins=%h pc=%h required ins=2222 pc=002",
                             instruction, pc);
                end
            end
        end
        checks++;
        if (instruction !== 16'h3333) begin
            errors++;
            $display("FAIL stall_resume: got %h required 3333", instruction);
        end
    endtask

    task automatic test_branch();
        obs_t e, a;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, (i == 0), 10'h100, 0, '0, '0);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL branch_step%0d: got %h required %h", i, a, e);
            end
        end
        checks++;
        if (instruction !== 16'hABCD || instr_pc !== 10'h100 || !instr_valid) begin
            errors++;
            $display("FAIL branch_target_word: got ins=%h ipc=%h v=%b required ABCD 100 1",
                     instruction, instr_pc, instr_valid);
        end
    endtask

    task automatic test_write_collision();
        obs_t e, a;
        logic [9:0] ad;
        ad = m_pc;
        for (int i = 0; i < 3; i++) begin
            // step 0: write+fetch same address; step 1: branch back; step 2: refetch
            cyc(0, 0, (i == 1), ad, (i == 0), ad, 16'hC0DE);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL collision_step%0d: got %h required %h", i, a, e);
            end
        end
        checks++;
        if (instruction !== 16'hC0DE) begin
            errors++;
            $display("FAIL collision_new_data: got %h required c0de", instruction);
        end
    endtask

    task automatic test_priority();
        obs_t e, a;
        logic [2:0] ctl [4];  // {stall, flush, branch}
        ctl = '{3'b110, 3'b000, 3'b101, 3'b000};
        for (int i = 0; i < 4; i++) begin
            cyc(ctl[i][2], ctl[i][1], ctl[i][0], 10'h200, 0, '0, '0);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL priority_step%0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t e, a;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, (i == 0), 10'h3FF, 0, '0, '0);
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL wrap_step%0d: got %h required %h", i, a, e);
            end
            if (i == 1) begin
                checks++;
                if (instruction !== 16'hBEEF || instr_pc_plus1 !== 10'd0 || pc !== 10'd0) begin
                    errors++;
                    $display("FAIL wrap_last: got ins=%h ipc1=%h pc=%h required BEEF 000 000",
                             instruction, instr_pc_plus1, pc);
                end
            end
        end
        checks++;
        if (instruction !== 16'h1111 || instr_pc !== 10'd0) begin
            errors++;
            $display("FAIL wrap_first: got ins=%h ipc=%h required 1111 000", instruction, instr_pc);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        for (int i = 0; i < 40; i++) begin
            logic s, f, b, we;
            logic [9:0] t, wa;
            s  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 6) == 0);
            we = ($urandom_range(0, 2) == 0);
            t  = 10'($urandom_range(0, 1023));
            wa = 10'($urandom_range(512, 767));  // keeps the T1/T3/T5 words intact
            cyc(s, f, b, t, we, wa, 16'($urandom));
            e = sb_q.pop_front();
            a = observe();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, a;
        cyc(0, 0, 0, '0, 0, '0, '0);
        void'(sb_q.pop_front());
        stall = 1'b1;
        #3;
        reset = 1'b1;  // mid-cycle, no clock edge involved
        #1;
        a = observe();
        checks++;
        if (a !== ResetObs) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", a, ResetObs);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        cyc(0, 0, 0, '0, 0, '0, '0);
        e = sb_q.pop_front();
        a = observe();
        checks++;
        if (a !== e || instruction !== 16'h1111) begin
            errors++;
            $display("FAIL reset_refetch: got %h required %h", a, e);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_write_collision();
        test_priority();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
